// File: rtl/alu_pkg.sv
// Shared ALU control definitions: command codes, result-unit selects, sequencer states.
package alu_pkg;

  // 3-bit ALU command codes as issued by the instruction front end
  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  // Result-unit select seen by the datapath output mux
  localparam logic [2:0] MUX_MATH = 3'd0;
  localparam logic [2:0] MUX_XOR  = 3'd1;
  localparam logic [2:0] MUX_AND  = 3'd2;
  localparam logic [2:0] MUX_NAND = 3'd3;
  localparam logic [2:0] MUX_NOR  = 3'd4;
  localparam logic [2:0] MUX_OR   = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational command decoder: ALU command -> datapath mux select, B inversion, carry-in.
module alu_cmd_decode
  import alu_pkg::*;
(
  input  logic [2:0] cmd,
  output logic [2:0] muxsel,
  output logic       inverse,
  output logic       carryin
);

  // Subtract and set-less-than both run the adder as a - b (invert B, carry in 1)
  always_comb begin
    muxsel  = MUX_MATH;
    inverse = 1'b0;
    carryin = 1'b0;
    case (cmd)
      CMD_ADD:  muxsel = MUX_MATH;
      CMD_SUB,
      CMD_SLT: begin
        muxsel  = MUX_MATH;
        inverse = 1'b1;
        carryin = 1'b1;
      end
      CMD_XOR:  muxsel = MUX_XOR;
      CMD_AND:  muxsel = MUX_AND;
      CMD_NAND: muxsel = MUX_NAND;
      CMD_NOR:  muxsel = MUX_NOR;
      CMD_OR:   muxsel = MUX_OR;
      default:  muxsel = MUX_MATH;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side sequencer for the combinational ALU: accepts one op, holds operands
// for a settle window, captures result/flags and hands them back over valid/ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_inverse,
  output logic             alu_carryin,
  output logic [2:0]       alu_muxsel,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_carryout,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             out_zero
);

  // Counter starts one below the window so capture lands on the SETTLE_CYCLES-th edge
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cmd_q;

  logic [2:0]       dec_muxsel;
  logic             dec_inverse;
  logic             dec_carryin;

  logic [WIDTH-1:0] cap_res;
  logic             cap_co;
  logic             cap_ov;

  alu_cmd_decode u_dec (
    .cmd     (in_cmd),
    .muxsel  (dec_muxsel),
    .inverse (dec_inverse),
    .carryin (dec_carryin)
  );

  // Shape raw datapath outputs per command; SLT folds the overflow into the sign bit
  always_comb begin
    cap_res = alu_res;
    cap_co  = alu_carryout;
    cap_ov  = alu_overflow;
    case (cmd_q)
      CMD_ADD,
      CMD_SUB: begin
        cap_co = alu_carryout;
      end
      CMD_SLT: begin
        cap_res    = '0;
        cap_res[0] = alu_res[WIDTH-1] ^ alu_overflow;
        cap_co     = 1'b0;
        cap_ov     = 1'b0;
      end
      default: begin
        cap_co = 1'b0;
        cap_ov = 1'b0;
      end
    endcase
  end

  // Request/settle/response FSM; all outputs registered, alu_* held between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      cnt          <= '0;
      cmd_q        <= CMD_ADD;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_inverse  <= 1'b0;
      alu_carryin  <= 1'b0;
      alu_muxsel   <= MUX_MATH;
      out_valid    <= 1'b0;
      out_res      <= '0;
      out_carryout <= 1'b0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a       <= in_a;
            alu_b       <= in_b;
            alu_muxsel  <= dec_muxsel;
            alu_inverse <= dec_inverse;
            alu_carryin <= dec_carryin;
            cmd_q       <= in_cmd;
            cnt         <= SETTLE_LOAD;
            in_ready    <= 1'b0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_res      <= cap_res;
            out_carryout <= cap_co;
            out_overflow <= cap_ov;
            out_zero     <= (cap_res == '0);
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; acceptance of the next op waits one more edge
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural 32-bit ALU datapath on the alu_* side,
// arithmetic reference model for expected responses, directed plus random ops.
module tb_alu_op_sequencer;

  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_cmd;
  logic [W-1:0]  in_a, in_b;
  logic [W-1:0]  alu_a, alu_b;
  logic          alu_inverse, alu_carryin;
  logic [2:0]    alu_muxsel;
  logic [W-1:0]  alu_res;
  logic          alu_carryout, alu_overflow;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_res;
  logic          out_carryout, out_overflow, out_zero;

  int n_chk  = 0;
  int n_fail = 0;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cmd       (in_cmd),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_inverse  (alu_inverse),
    .alu_carryin  (alu_carryin),
    .alu_muxsel   (alu_muxsel),
    .alu_res      (alu_res),
    .alu_carryout (alu_carryout),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_carryout (out_carryout),
    .out_overflow (out_overflow),
    .out_zero     (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: adder with B inversion, logic units, output mux
  logic [W-1:0] bx;
  logic [W:0]   sum;
  always_comb begin
    bx           = alu_inverse ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, bx} + {{W{1'b0}}, alu_carryin};
    alu_carryout = sum[W];
    alu_overflow = (alu_a[W-1] == bx[W-1]) && (sum[W-1] != alu_a[W-1]);
    case (alu_muxsel)
      3'd0:    alu_res = sum[W-1:0];
      3'd1:    alu_res = alu_a ^ alu_b;
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = ~(alu_a & alu_b);
      3'd4:    alu_res = ~(alu_a | alu_b);
      3'd5:    alu_res = alu_a | alu_b;
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what the op means arithmetically, independent of how the ALU computes it
  task automatic model(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic co, output logic ov);
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    co = 1'b0;
    ov = 1'b0;
    case (cmd)
      3'd0: begin
        r  = a + b;
        co = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        sr = sa + sb;
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        co = (a >= b);
        sr = sa - sb;
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd3:    r = (sa < sb) ? 32'd1 : 32'd0;
      3'd2:    r = a ^ b;
      3'd4:    r = a & b;
      3'd5:    r = ~(a & b);
      3'd6:    r = ~(a | b);
      default: r = a | b;
    endcase
  endtask

  function automatic logic [2:0] exp_mux(input logic [2:0] cmd);
    case (cmd)
      3'd2:    return 3'd1;
      3'd4:    return 3'd2;
      3'd5:    return 3'd3;
      3'd6:    return 3'd4;
      3'd7:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_sub(input logic [2:0] cmd);
    return (cmd == 3'd1) || (cmd == 3'd3);
  endfunction

  // Issue one op, check latency, held controls and the captured response, then drain
  task automatic run_op(input logic [2:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] er;
    logic         eco, eov;
    int           k;
    model(cmd, a, b, er, eco, eov);
    @(negedge clk);
    chk("idle_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    // Scramble inputs: nothing outside IDLE may react to them
    in_valid = 1'b0;
    in_cmd   = 3'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    chk("busy_ready", {63'd0, in_ready}, 64'd0);
    chk("alu_a", {32'd0, alu_a}, {32'd0, a});
    chk("alu_b", {32'd0, alu_b}, {32'd0, b});
    chk("muxsel", {61'd0, alu_muxsel}, {61'd0, exp_mux(cmd)});
    chk("ctl", {62'd0, alu_inverse, alu_carryin}, {62'd0, is_sub(cmd), is_sub(cmd)});
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 64'(k), 64'(SETTLE));
    chk("ctl_held", {62'd0, alu_inverse, alu_carryin}, {62'd0, is_sub(cmd), is_sub(cmd)});
    chk("res", {32'd0, out_res}, {32'd0, er});
    chk("flags", {61'd0, out_carryout, out_overflow, out_zero}, {61'd0, eco, eov, er == 0});
    chk("done_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold", {31'd0, out_valid, out_res}, {31'd0, 1'b1, er});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra, rb;
    logic [2:0]   rc;
    int           k;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_cmd    = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out", {29'd0, out_valid, out_carryout, out_overflow, out_zero, out_res},
        {29'd0, 4'b0001, 32'd0});
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    chk("rst_ctl", {58'd0, alu_inverse, alu_carryin, alu_muxsel, in_ready}, {58'd0, 6'b000001});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: arithmetic, SLT corners, logic units
    run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(3'd1, 32'd5, 32'd5, 1);
    run_op(3'd1, 32'd0, 32'd1, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    run_op(3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    run_op(3'd5, 32'hFFFF_0000, 32'hFF00_FF00, 0);
    run_op(3'd6, 32'hFFFF_0000, 32'hFF00_FF00, 0);
    run_op(3'd2, 32'hFFFF_0000, 32'hFF00_FF00, 0);
    run_op(3'd4, 32'hFFFF_0000, 32'hFF00_FF00, 0);
    run_op(3'd7, 32'hFFFF_0000, 32'hFF00_FF00, 0);

    // Backpressure: second request waits while the first response is stalled
    @(negedge clk);
    in_valid = 1'b1; in_cmd = 3'd0; in_a = 32'd100; in_b = 32'd23;
    @(posedge clk); #1;
    in_cmd = 3'd1; in_a = 32'd50; in_b = 32'd8;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_latency", 64'(k), 64'(SETTLE));
    held = out_res;
    chk("bp_first", {32'd0, held}, 64'd123);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stall", {30'd0, out_valid, in_ready, out_res}, {30'd0, 2'b10, 32'd123});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_handshake", {30'd0, out_valid, in_ready, alu_a}, {30'd0, 2'b01, 32'd100});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept", {31'd0, in_ready, alu_a}, {31'd0, 1'b0, 32'd50});
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_second", {31'd0, out_valid, out_res}, {31'd0, 1'b1, 32'd42});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset two edges into the settle window
    @(negedge clk);
    in_valid = 1'b1; in_cmd = 3'd0; in_a = 32'h1234; in_b = 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {29'd0, out_valid, out_carryout, out_overflow, out_zero, out_res},
        {29'd0, 4'b0001, 32'd0});
    chk("mid_rst_alu", {alu_a, alu_b}, 64'd0);
    chk("mid_rst_ctl", {58'd0, alu_inverse, alu_carryin, alu_muxsel, in_ready}, {58'd0, 6'b000001});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_quiet", {63'd0, out_valid}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd2, 32'd3, 0);

    // Random ops, biased toward sign/carry corners, random response stalls
    for (int n = 0; n < 40; n++) begin
      rc = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 32'h7FFF_FFFF;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(rc, ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
